// File: rtl/xor_stream_cipher.sv
// xor_stream_cipher: loads a KEY_SIZE-bit key in LANES-bit beats, then XORs a MSG_SIZE-bit frame
// with the repeating key at one beat per cycle. Define XOR_KEY_ROLL_EN to rotate the key left 1 bit per key period.
module xor_stream_cipher #(
    parameter int LANES    = 1,
    parameter int KEY_SIZE = 32,
    parameter int MSG_SIZE = 512
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic             iLoad_key,
    input  logic             iLoad_msg,
    input  logic [LANES-1:0] iData_in,
    output logic [LANES-1:0] oData_out,
    output logic             oValid,
    output logic             oSerial_start,
    output logic             oSerial_end,
    output logic             oKey_ready,
    output logic             oBusy
);
    localparam int NK = KEY_SIZE / LANES;
    localparam int NM = MSG_SIZE / LANES;
    localparam int PW = (NK > 1) ? $clog2(NK) : 1;
    localparam int KW = $clog2(NK + 1);
    localparam int MW = $clog2(NM + 1);
    localparam logic [PW-1:0] P_LAST = PW'(NK - 1);
    localparam logic [KW-1:0] K_LAST = KW'(NK - 1);
    localparam logic [MW-1:0] M_LAST = MW'(NM - 1);

    typedef enum logic [1:0] {IDLE, KEY, MSG, DONE} state_t;

    state_t              r_state;
    logic [KEY_SIZE-1:0] r_base_key, r_work_key;
    logic [KW-1:0]       r_kcnt;
    logic [PW-1:0]       r_p;
    logic [MW-1:0]       r_mcnt;

    logic                w_idle, w_key_in, w_emit, w_key_last, w_wrap, w_last;
    logic [KEY_SIZE-1:0] w_base_next, w_src, w_circ, w_work_next;
    logic [KW-1:0]       w_kc;
    logic [PW-1:0]       w_p;
    logic [MW-1:0]       w_m;

    // The first beat of a key or frame is consumed in IDLE, so counters read as zero there
    always_comb begin
        w_idle      = r_state == IDLE;
        w_key_in    = iEn && iLoad_key && (w_idle || r_state == KEY);
        w_emit      = iEn && iLoad_msg && (w_idle ? (!iLoad_key && oKey_ready) : r_state == MSG);
        w_kc        = w_idle ? '0 : r_kcnt;
        w_p         = w_idle ? '0 : r_p;
        w_m         = w_idle ? '0 : r_mcnt;
        w_key_last  = w_kc == K_LAST;
        w_wrap      = w_p == P_LAST;
        w_last      = w_m == M_LAST;
        w_base_next = (r_base_key << LANES) | KEY_SIZE'(iData_in);
        w_src       = w_idle ? r_base_key : r_work_key;
        // Working key is rotated by one lane per beat so the active slice is always the top one
        w_circ      = (w_src << LANES) | (w_src >> (KEY_SIZE - LANES));
`ifdef XOR_KEY_ROLL_EN
        w_work_next = w_wrap ? {w_circ[KEY_SIZE-2:0], w_circ[KEY_SIZE-1]} : w_circ;
`else
        w_work_next = w_circ;
`endif
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state       <= IDLE;
            r_base_key    <= '0;
            r_work_key    <= '0;
            r_kcnt        <= '0;
            r_p           <= '0;
            r_mcnt        <= '0;
            oData_out     <= '0;
            oValid        <= 1'b0;
            oSerial_start <= 1'b0;
            oSerial_end   <= 1'b0;
            oKey_ready    <= 1'b0;
        end else begin
            oValid        <= w_emit;
            oSerial_start <= w_emit && w_m == '0;
            oSerial_end   <= w_emit && w_last;
            if (w_emit) begin
                oData_out  <= iData_in ^ w_src[KEY_SIZE-1 -: LANES];
                r_work_key <= w_work_next;
                r_p        <= w_wrap ? '0 : w_p + 1'b1;
                r_mcnt     <= w_m + 1'b1;
            end
            if (w_key_in) begin
                r_base_key <= w_base_next;
                r_kcnt     <= w_key_last ? '0 : w_kc + 1'b1;
                oKey_ready <= w_key_last;
                r_state    <= w_key_last ? IDLE : KEY;
            end else if (w_emit) begin
                r_state <= w_last ? DONE : MSG;
            end else if (r_state == DONE) begin
                r_kcnt  <= '0;
                r_p     <= '0;
                r_mcnt  <= '0;
                r_state <= IDLE;
            end
        end
    end

    assign oBusy = r_state == KEY || r_state == MSG;
endmodule

// File: tb/tb_xor_stream_cipher.sv
// tb_xor_stream_cipher: two instances (1-bit and 4-bit lanes, 8-bit key, 16-bit frame) checked
// every cycle against a bitwise repeating-key XOR model, with randomized keys, frames and stalls.
module tb_xor_stream_cipher;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] en = '0, lk = '0, lm = '0;
    logic [0:0] din_a = '0;
    logic [3:0] din_b = '0;
    logic [0:0] dout_a;
    logic [3:0] dout_b;
    logic [1:0] valid, sst, send, kr, busy;

    logic [1:0]  nxt_v = '0, nxt_s = '0, nxt_e = '0, nxt_kr = '0;
    logic [1:0]  cur_v, cur_s, cur_e, cur_kr;
    logic [3:0]  nxt_d [2];
    logic [3:0]  cur_d [2];
    logic [7:0]  mkey [2];
    logic [15:0] cap [2];
    int          cnt_v [2], cnt_s [2], cnt_e [2];
    int          n_pass = 0, n_tot = 0;

`ifdef XOR_KEY_ROLL_EN
    localparam logic [15:0] EXP1 = 16'h9944;
`else
    localparam logic [15:0] EXP1 = 16'h99AA;
`endif

    xor_stream_cipher #(.LANES(1), .KEY_SIZE(8), .MSG_SIZE(16)) u_a (
        .iClk(clk), .iRst(rst), .iEn(en[0]), .iLoad_key(lk[0]), .iLoad_msg(lm[0]),
        .iData_in(din_a), .oData_out(dout_a), .oValid(valid[0]), .oSerial_start(sst[0]),
        .oSerial_end(send[0]), .oKey_ready(kr[0]), .oBusy(busy[0])
    );

    xor_stream_cipher #(.LANES(4), .KEY_SIZE(8), .MSG_SIZE(16)) u_b (
        .iClk(clk), .iRst(rst), .iEn(en[1]), .iLoad_key(lk[1]), .iLoad_msg(lm[1]),
        .iData_in(din_b), .oData_out(dout_b), .oValid(valid[1]), .oSerial_start(sst[1]),
        .oSerial_end(send[1]), .oKey_ready(kr[1]), .oBusy(busy[1])
    );

    always #5 clk = ~clk;

    // Ciphertext bit i (MSB first) = message bit ^ key bit (i mod 8), key rolled once per full key period
    function automatic logic [15:0] cipher(input logic [15:0] m, input logic [7:0] k);
        logic [7:0] kk;
        cipher = '0;
        for (int i = 0; i < 16; i++) begin
            kk = k;
`ifdef XOR_KEY_ROLL_EN
            for (int r = 0; r < i / 8; r++) kk = {kk[6:0], kk[7]};
`endif
            cipher[15-i] = m[15-i] ^ kk[7-(i%8)];
        end
    endfunction

    task automatic check(input string nm, input int s, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, s, act, exp, $time);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_v <= '0; cur_s <= '0; cur_e <= '0; cur_kr <= '0;
            cur_d[0] <= '0; cur_d[1] <= '0;
        end else begin
            cur_v <= nxt_v; cur_s <= nxt_s; cur_e <= nxt_e; cur_kr <= nxt_kr;
            cur_d[0] <= nxt_d[0]; cur_d[1] <= nxt_d[1];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                check("valid", s, 16'(valid[s]), 16'(cur_v[s]));
                check("data", s, (s == 0) ? 16'(dout_a) : 16'(dout_b), 16'(cur_d[s]));
                check("start", s, 16'(sst[s]), 16'(cur_s[s]));
                check("end", s, 16'(send[s]), 16'(cur_e[s]));
                check("key_ready", s, 16'(kr[s]), 16'(cur_kr[s]));
                if (valid[s]) begin
                    cap[s] = (s == 0) ? {cap[s][14:0], dout_a} : {cap[s][11:0], dout_b};
                    cnt_v[s]++;
                    if (sst[s]) cnt_s[s]++;
                end
                if (send[s]) cnt_e[s]++;
            end
        end
    end

    task automatic drive(input int s, input logic e, input logic k, input logic m, input logic [3:0] d);
        en[s] = e; lk[s] = k; lm[s] = m;
        if (s == 0) din_a = d[0];
        else din_b = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        en = '0; lk = '0; lm = '0;
        nxt_v = '0; nxt_s = '0; nxt_e = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = '0; lk = '0; lm = '0;
        nxt_v = '0; nxt_s = '0; nxt_e = '0; nxt_kr = '0;
        nxt_d[0] = '0; nxt_d[1] = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic out_zero(input int s);
        check("rst_valid", s, 16'(valid[s]), 16'h0);
        check("rst_data", s, (s == 0) ? 16'(dout_a) : 16'(dout_b), 16'h0);
        check("rst_start", s, 16'(sst[s]), 16'h0);
        check("rst_end", s, 16'(send[s]), 16'h0);
        check("rst_key_ready", s, 16'(kr[s]), 16'h0);
        check("rst_busy", s, 16'(busy[s]), 16'h0);
    endtask

    task automatic load_key(input int s, input logic [7:0] key, input logic both);
        int l, nb, ns;
        logic [7:0] kh;
        l = (s == 0) ? 1 : 4;
        nb = 8 / l;
        mkey[s] = key;
        for (int j = 0; j < nb; j++) begin
            ns = $urandom_range(0, 2);
            for (int t = 0; t < ns; t++) begin
                if (j > 0 && $urandom_range(0, 1) == 1) drive(s, 1'b1, 1'b0, 1'b1, 4'($urandom));
                else drive(s, 1'b0, 1'($urandom), 1'($urandom), 4'($urandom));
                tick();
            end
            kh = key >> (8 - (j + 1) * l);
            drive(s, 1'b1, 1'b1, (j == 0) ? both : 1'($urandom), (s == 0) ? {3'b0, kh[0]} : kh[3:0]);
            if (j == 0) nxt_kr[s] = 1'b0;
            if (j == nb - 1) nxt_kr[s] = 1'b1;
            tick();
            if (j == 0) check("busy_key", s, 16'(busy[s]), 16'h1);
        end
    endtask

    task automatic send_frame(input int s, input logic [15:0] msg, input int stop);
        int l, nb, ns;
        logic [15:0] exp, sh, eh;
        l = (s == 0) ? 1 : 4;
        nb = 16 / l;
        exp = cipher(msg, mkey[s]);
        cap[s] = '0; cnt_v[s] = 0; cnt_s[s] = 0; cnt_e[s] = 0;
        for (int j = 0; j < nb; j++) begin
            ns = $urandom_range(0, 2) + ((j == 2) ? 2 : 0);
            for (int t = 0; t < ns; t++) begin
                if (j > 0 && $urandom_range(0, 1) == 1) drive(s, 1'b1, 1'b1, 1'b0, 4'($urandom));
                else drive(s, 1'b0, 1'($urandom), 1'($urandom), 4'($urandom));
                tick();
            end
            sh = msg >> (16 - (j + 1) * l);
            eh = exp >> (16 - (j + 1) * l);
            drive(s, 1'b1, (j > 0) ? 1'($urandom) : 1'b0, 1'b1, (s == 0) ? {3'b0, sh[0]} : sh[3:0]);
            nxt_v[s] = 1'b1;
            nxt_d[s] = (s == 0) ? {3'b0, eh[0]} : eh[3:0];
            nxt_s[s] = j == 0;
            nxt_e[s] = j == nb - 1;
            tick();
            if (stop == j + 1) return;
        end
        drive(s, 1'b1, 1'b0, 1'b1, 4'($urandom));
        tick();
    endtask

    task automatic frame_checks(input int s, input logic [15:0] exp);
        check("frame", s, cap[s], exp);
        check("nbeats", s, 16'(cnt_v[s]), (s == 0) ? 16'd16 : 16'd4);
        check("nstart", s, 16'(cnt_s[s]), 16'd1);
        check("nend", s, 16'(cnt_e[s]), 16'd1);
    endtask

    initial begin
        logic [15:0] msg;
        int s;
        nxt_d[0] = '0; nxt_d[1] = '0;
        do_reset();
        out_zero(0);
        out_zero(1);
        rst = 1'b0;
        check("model", 0, cipher(16'h3C0F, 8'hA5), EXP1);
        check("model_ff", 0, cipher(16'h0000, 8'hFF), 16'hFFFF);

        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b1, 1'b0, 1'b1, 4'($urandom));
            tick();
            check("nokey_busy", 0, 16'(busy[0]), 16'h0);
        end
        load_key(0, 8'hA5, 1'b1);
        send_frame(0, 16'h3C0F, 0);
        frame_checks(0, EXP1);
        send_frame(0, 16'h3C0F, 0);
        frame_checks(0, EXP1);

        load_key(1, 8'hA5, 1'b0);
        send_frame(1, 16'h3C0F, 0);
        frame_checks(1, EXP1);

        for (int it = 0; it < 30; it++) begin
            s = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) load_key(s, 8'($urandom), 1'($urandom));
            msg = 16'($urandom);
            send_frame(s, msg, 0);
            frame_checks(s, cipher(msg, mkey[s]));
        end

        load_key(0, 8'($urandom), 1'b0);
        send_frame(0, 16'($urandom), 5);
        #2 rst = 1'b1;
        #1;
        out_zero(0);
        out_zero(1);
        do_reset();
        rst = 1'b0;
        check("abort_end", 0, 16'(cnt_e[0]), 16'h0);
        load_key(0, 8'hFF, 1'b0);
        send_frame(0, 16'h0000, 0);
        frame_checks(0, 16'hFFFF);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
